// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - register file write-port arbiter bus bundle
interface rf_wb_arbiter_if #(
    parameter int DW = 32
) ();
    logic          wb_we;
    logic [3:0]    wb_wa;
    logic [DW-1:0] wb_wd;
    logic          b_valid;
    logic          b_ready;
    logic [3:0]    b_wa;
    logic [DW-1:0] b_wd;
    logic          rf_we;
    logic [3:0]    rf_wa;
    logic [DW-1:0] rf_wd;
    logic [15:0]   pend_mask;
    logic          stall_req;
    logic          err_r15;

    modport slave (
        input  wb_we, wb_wa, wb_wd, b_valid, b_wa, b_wd,
        output b_ready, rf_we, rf_wa, rf_wd, pend_mask, stall_req, err_r15
    );

    modport master (
        output wb_we, wb_wa, wb_wd, b_valid, b_wa, b_wd,
        input  b_ready, rf_we, rf_wa, rf_wd, pend_mask, stall_req, err_r15
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - regfile write-port arbiter: writeback priority, buffered long-latency results
module rf_wb_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8,
    parameter int DW       = 32
) (
    input logic            clk,
    input logic            reset_n,
    rf_wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [WW-1:0] MAXW_C = WW'(MAX_WAIT);
    localparam logic [3:0]    R15    = 4'd15;

    logic [3:0]    r_wa [DEPTH];
    logic [DW-1:0] r_wd [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [WW-1:0] r_wait;
    logic          r_stall;
    logic          r_err;

    logic          w_empty;
    logic          w_full;
    logic          w_head_vld;
    logic          w_a_win;
    logic          w_xfer;
    logic          w_bypass;
    logic          w_pop;
    logic          w_push;
    logic          w_b_r15;
    logic          w_b_squash;
    logic [WW-1:0] w_wait_nxt;
    logic          w_rf_we;
    logic [3:0]    w_rf_wa;
    logic [DW-1:0] w_rf_wd;
    logic [15:0]   w_pend;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_C);
    assign w_head_vld = !w_empty && r_vld[r_rd_ptr];
    // R15 is the PC in the regfile, so port A never claims the write port for it
    assign w_a_win    = bus.wb_we && (bus.wb_wa != R15);
    assign w_xfer     = bus.b_valid && !w_full;
    // the FIFO drains whenever A is idle, even if the head was squashed
    assign w_pop      = !w_a_win && !w_empty;
    assign w_bypass   = !w_a_win && w_empty && bus.b_valid;
    assign w_b_r15    = (bus.b_wa == R15);
    assign w_b_squash = w_a_win && (bus.b_wa == bus.wb_wa);
    // results that would be dropped anyway never take a slot
    assign w_push     = w_xfer && !w_bypass && !w_b_r15 && !w_b_squash;

    // write-port source selection: A, then FIFO head, then zero-latency bypass
    always_comb begin
        w_rf_we = 1'b0;
        w_rf_wa = bus.wb_wa;
        w_rf_wd = bus.wb_wd;
        if (w_a_win) begin
            w_rf_we = 1'b1;
        end else if (!w_empty) begin
            w_rf_we = r_vld[r_rd_ptr];
            w_rf_wa = r_wa[r_rd_ptr];
            w_rf_wd = r_wd[r_rd_ptr];
        end else if (bus.b_valid) begin
            w_rf_we = !w_b_r15;
            w_rf_wa = bus.b_wa;
            w_rf_wd = bus.b_wd;
        end
    end

    // hazard mask: every still-valid buffered destination
    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i]) begin
                w_pend[r_wa[i]] = 1'b1;
            end
        end
    end

    // starvation counter: counts cycles a valid head loses to A, saturating
    always_comb begin
        w_wait_nxt = r_wait;
        if (w_empty || w_pop) begin
            w_wait_nxt = '0;
        end else if (w_head_vld && (r_wait != MAXW_C)) begin
            w_wait_nxt = r_wait + WW'(1);
        end
    end

    // FIFO control, squash, starvation and error state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_wait   <= '0;
            r_stall  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_a_win && r_vld[i] && (r_wa[i] == bus.wb_wa)) begin
                    r_vld[i] <= 1'b0;
                end
            end
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + PW'(1);
            end
            if (w_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_wait  <= w_wait_nxt;
            r_stall <= (w_wait_nxt == MAXW_C);
            r_err   <= (bus.wb_we && (bus.wb_wa == R15)) || (w_xfer && w_b_r15);
        end
    end

    // entry payload storage, written only on enqueue
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_wa[r_wr_ptr] <= bus.b_wa;
            r_wd[r_wr_ptr] <= bus.b_wd;
        end
    end

    assign bus.b_ready   = reset_n && !w_full;
    assign bus.rf_we     = reset_n && w_rf_we;
    assign bus.rf_wa     = w_rf_wa;
    assign bus.rf_wd     = w_rf_wd;
    assign bus.pend_mask = w_pend;
    assign bus.stall_req = r_stall;
    assign bus.err_r15   = r_err;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;
    localparam int DW       = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.DW(DW)) bus ();

    rf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .DW(DW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]    wa;
        logic [DW-1:0] wd;
        bit            ok;
    } ent_t;

    ent_t mq[$];
    int   mwait;
    bit   mstall;
    bit   merr;

    bit            e_we;
    logic [3:0]    e_wa;
    logic [DW-1:0] e_wd;
    bit            e_ready;
    logic [15:0]   e_pend;

    logic [DW-1:0] rf_img [16];
    logic [DW-1:0] ref_rf [16];

    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.rf_we === 1'b1) rf_img[bus.rf_wa] = bus.rf_wd;
    end

    task automatic model_reset();
        mq.delete();
        mwait  = 0;
        mstall = 0;
        merr   = 0;
    endtask

    task automatic model_expect();
        bit a;
        a = bus.wb_we && (bus.wb_wa != 4'd15);
        e_we = 0;
        e_wa = bus.wb_wa;
        e_wd = bus.wb_wd;
        if (a) e_we = 1;
        else if (mq.size() > 0) begin
            e_we = mq[0].ok; e_wa = mq[0].wa; e_wd = mq[0].wd;
        end else if (bus.b_valid) begin
            e_we = (bus.b_wa != 4'd15); e_wa = bus.b_wa; e_wd = bus.b_wd;
        end
        e_ready = (mq.size() < DEPTH);
        e_pend = '0;
        foreach (mq[i]) if (mq[i].ok) e_pend[mq[i].wa] = 1'b1;
    endtask

    task automatic model_update();
        bit a, xfer, bypass, head_ok;
        int sz;
        sz      = mq.size();
        a       = bus.wb_we && (bus.wb_wa != 4'd15);
        xfer    = bus.b_valid && (sz < DEPTH);
        bypass  = !a && (sz == 0) && bus.b_valid;
        head_ok = (sz > 0) && mq[0].ok;
        if (e_we) ref_rf[e_wa] = e_wd;
        merr = (bus.wb_we && bus.wb_wa == 4'd15) || (xfer && bus.b_wa == 4'd15);
        if (a) foreach (mq[i]) if (mq[i].wa == bus.wb_wa) mq[i].ok = 0;
        if (!a && sz > 0) begin
            void'(mq.pop_front());
            mwait = 0;
        end else if (sz == 0) mwait = 0;
        else if (head_ok && mwait < MAX_WAIT) mwait++;
        if (xfer && !bypass && bus.b_wa != 4'd15 && !(a && bus.b_wa == bus.wb_wa))
            mq.push_back('{bus.b_wa, bus.b_wd, 1'b1});
        mstall = (mwait == MAX_WAIT);
    endtask

    task automatic set_in(bit we, logic [3:0] wa, logic [DW-1:0] wd,
                          bit bv, logic [3:0] bwa, logic [DW-1:0] bwd);
        bus.wb_we = we; bus.wb_wa = wa; bus.wb_wd = wd;
        bus.b_valid = bv; bus.b_wa = bwa; bus.b_wd = bwd;
        model_expect();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        bus.wb_we = 0; bus.wb_wa = 0; bus.wb_wd = 0;
        bus.b_valid = 1; bus.b_wa = 4'd3; bus.b_wd = 32'h55;
        #3;
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we got %b want 0", bus.rf_we); end
        checks++; if (bus.pend_mask !== 16'h0) begin errors++; $display("FAIL rst_pend got %h want 0", bus.pend_mask); end
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", bus.stall_req); end
        checks++; if (bus.err_r15 !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", bus.err_r15); end
        bus.b_valid = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL rst_b_ready got %b want 1", bus.b_ready); end
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rst_idle_we got %b want 0", bus.rf_we); end
        tick();
    endtask

    task automatic test_bypass();
        set_in(0, 0, 0, 1, 4'd3, 32'h1234);
        checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL byp_we got %b want 1", bus.rf_we); end
        checks++; if (bus.rf_wa !== 4'd3) begin errors++; $display("FAIL byp_wa got %0d want 3", bus.rf_wa); end
        checks++; if (bus.rf_wd !== 32'h1234) begin errors++; $display("FAIL byp_wd got %h want 1234", bus.rf_wd); end
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (bus.pend_mask !== 16'h0) begin errors++; $display("FAIL byp_pend got %h want 0", bus.pend_mask); end
        tick();
    endtask

    task automatic test_conflict_drain();
        set_in(1, 4'd2, 32'hA, 1, 4'd5, 32'hB);
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_wa !== 4'd2 || bus.rf_wd !== 32'hA) begin
            errors++; $display("FAIL cfl_a got we=%b wa=%0d wd=%h want 1/2/a", bus.rf_we, bus.rf_wa, bus.rf_wd); end
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (bus.pend_mask !== 16'h0020) begin errors++; $display("FAIL cfl_pend got %h want 0020", bus.pend_mask); end
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_wa !== 4'd5 || bus.rf_wd !== 32'hB) begin
            errors++; $display("FAIL cfl_drain got we=%b wa=%0d wd=%h want 1/5/b", bus.rf_we, bus.rf_wa, bus.rf_wd); end
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (bus.pend_mask !== 16'h0) begin errors++; $display("FAIL cfl_pend_clr got %h want 0", bus.pend_mask); end
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL cfl_idle got %b want 0", bus.rf_we); end
        tick();
    endtask

    task automatic test_full_backpressure();
        int waited;
        for (int k = 0; k < 4; k++) begin
            set_in(1, 4'd1, 32'h100 + k, 1, 4'(4 + k), 32'h40 + k);
            checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d got %b want 1", k, bus.b_ready); end
            tick();
        end
        waited = 3;
        while (waited < 10) begin
            set_in(1, 4'd1, 32'h200 + waited, 1, 4'd9, 32'h99);
            checks++; if (bus.b_ready !== 1'b0) begin errors++; $display("FAIL full_bp got %b want 0", bus.b_ready); end
            checks++; if (bus.pend_mask !== 16'h00F0) begin errors++; $display("FAIL full_pend got %h want 00f0", bus.pend_mask); end
            checks++; if (bus.stall_req !== (waited >= MAX_WAIT)) begin
                errors++; $display("FAIL full_stall_w%0d got %b want %b", waited, bus.stall_req, waited >= MAX_WAIT); end
            tick();
            waited++;
        end
        for (int j = 0; j < 4; j++) begin
            set_in(0, 0, 0, 0, 0, 0);
            checks++; if (bus.rf_we !== 1'b1 || bus.rf_wa !== 4'(4 + j) || bus.rf_wd !== 32'h40 + j) begin
                errors++; $display("FAIL drain_%0d got we=%b wa=%0d wd=%h want 1/%0d/%h", j, bus.rf_we, bus.rf_wa, bus.rf_wd, 4 + j, 32'h40 + j); end
            checks++; if (bus.stall_req !== (j == 0)) begin errors++; $display("FAIL drain_stall_%0d got %b want %b", j, bus.stall_req, j == 0); end
            checks++; if (bus.b_ready !== (j != 0)) begin errors++; $display("FAIL drain_ready_%0d got %b want %b", j, bus.b_ready, j != 0); end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (bus.pend_mask !== 16'h0) begin errors++; $display("FAIL drain_pend got %h want 0", bus.pend_mask); end
        tick();
    endtask

    task automatic test_squash();
        set_in(1, 4'd1, 32'h5, 1, 4'd6, 32'h11);
        tick();
        set_in(1, 4'd6, 32'h22, 0, 0, 0);
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_wa !== 4'd6 || bus.rf_wd !== 32'h22) begin
            errors++; $display("FAIL sq_a got we=%b wa=%0d wd=%h want 1/6/22", bus.rf_we, bus.rf_wa, bus.rf_wd); end
        checks++; if (bus.pend_mask !== 16'h0040) begin errors++; $display("FAIL sq_pend got %h want 0040", bus.pend_mask); end
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL sq_pop_we got %b want 0", bus.rf_we); end
        checks++; if (bus.pend_mask !== 16'h0) begin errors++; $display("FAIL sq_pend_clr got %h want 0", bus.pend_mask); end
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (rf_img[6] !== 32'h22) begin errors++; $display("FAIL sq_r6 got %h want 22", rf_img[6]); end
        tick();
    endtask

    task automatic test_r15();
        set_in(1, 4'd15, 32'hDEAD, 1, 4'd8, 32'h88);
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_wa !== 4'd8 || bus.rf_wd !== 32'h88) begin
            errors++; $display("FAIL r15_byp got we=%b wa=%0d wd=%h want 1/8/88", bus.rf_we, bus.rf_wa, bus.rf_wd); end
        checks++; if (bus.err_r15 !== 1'b0) begin errors++; $display("FAIL r15_err_early got %b want 0", bus.err_r15); end
        tick();
        set_in(0, 0, 0, 1, 4'd15, 32'h99);
        checks++; if (bus.err_r15 !== 1'b1) begin errors++; $display("FAIL r15_err_a got %b want 1", bus.err_r15); end
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL r15_b_we got %b want 0", bus.rf_we); end
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (bus.err_r15 !== 1'b1) begin errors++; $display("FAIL r15_err_b got %b want 1", bus.err_r15); end
        checks++; if (bus.pend_mask !== 16'h0) begin errors++; $display("FAIL r15_pend got %h want 0", bus.pend_mask); end
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (bus.err_r15 !== 1'b0) begin errors++; $display("FAIL r15_err_end got %b want 0", bus.err_r15); end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 4'd1, 32'h300 + k, 1, 4'(10 + k), 32'hA0 + k);
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            set_in(1, 4'd1, 32'h310 + k, 0, 0, 0);
            tick();
        end
        #1;
        checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL mid_stall_pre got %b want 1", bus.stall_req); end
        checks++; if (bus.pend_mask !== 16'h1C00) begin errors++; $display("FAIL mid_pend_pre got %h want 1c00", bus.pend_mask); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL mid_we got %b want 0", bus.rf_we); end
        checks++; if (bus.pend_mask !== 16'h0) begin errors++; $display("FAIL mid_pend got %h want 0", bus.pend_mask); end
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL mid_stall got %b want 0", bus.stall_req); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 0, 0, 0, 0);
            checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL mid_stale_%0d got %b want 0", k, bus.rf_we); end
            checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_%0d got %b want 1", k, bus.b_ready); end
            tick();
        end
    endtask

    task automatic test_random();
        bit bv, hold;
        logic [3:0] bwa;
        logic [DW-1:0] bwd;
        int wp;
        hold = 0; bv = 0; bwa = 0; bwd = 0;
        for (int c = 0; c < 600; c++) begin
            wp = ((c / 40) % 2) ? 85 : 30;
            if (!hold) begin
                bv  = ($urandom_range(0, 99) < 60);
                bwa = 4'($urandom_range(0, 15));
                bwd = $urandom;
            end
            set_in($urandom_range(0, 99) < wp, 4'($urandom_range(0, 15)), $urandom, bv, bwa, bwd);
            checks++; if (bus.rf_we !== e_we) begin errors++; $display("FAIL rnd_we c%0d got %b want %b", c, bus.rf_we, e_we); end
            if (e_we) begin
                checks++; if (bus.rf_wa !== e_wa || bus.rf_wd !== e_wd) begin
                    errors++; $display("FAIL rnd_wdata c%0d got %0d/%h want %0d/%h", c, bus.rf_wa, bus.rf_wd, e_wa, e_wd); end
            end
            checks++; if (bus.b_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d got %b want %b", c, bus.b_ready, e_ready); end
            checks++; if (bus.pend_mask !== e_pend) begin errors++; $display("FAIL rnd_pend c%0d got %h want %h", c, bus.pend_mask, e_pend); end
            checks++; if (bus.stall_req !== mstall) begin errors++; $display("FAIL rnd_stall c%0d got %b want %b", c, bus.stall_req, mstall); end
            checks++; if (bus.err_r15 !== merr) begin errors++; $display("FAIL rnd_err c%0d got %b want %b", c, bus.err_r15, merr); end
            hold = bv && !e_ready;
            tick();
        end
        for (int c = 0; c < DEPTH + 2; c++) begin
            set_in(0, 0, 0, 0, 0, 0);
            tick();
        end
        for (int r = 0; r < 16; r++) begin
            checks++; if (rf_img[r] !== ref_rf[r]) begin errors++; $display("FAIL rf_image r%0d got %h want %h", r, rf_img[r], ref_rf[r]); end
        end
    endtask

    initial begin
        for (int r = 0; r < 16; r++) begin
            rf_img[r] = '0;
            ref_rf[r] = '0;
        end
        model_reset();
        test_reset();
        test_bypass();
        test_conflict_drain();
        test_full_backpressure();
        test_squash();
        test_r15();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
